// File: rtl/booth_mul_seq_if.sv
// booth_mul_seq_if
//   Operand/result bundle for the sequential Booth multiplier.
//
//   Handshake semantics (both sides): a transfer happens at a rising clock
//   edge where valid and ready are both high.  The producer holds its payload
//   stable while valid is high; the consumer may raise or drop ready at will.
//   On the input side ready is high only in IDLE; on the output side valid is
//   high only in DONE, so the two are never high together.
//
//   Signals:
//     in_valid / in_ready         operand pair handshake
//     multiplicand, multiplier    WIDTH-bit operands
//     signed_mode                 1 = two's complement, 0 = unsigned
//     abort                       cancel the operation in flight
//     out_valid / out_ready       product handshake
//     product                     2*WIDTH-bit result
//     busy                        operation in CALC or DONE
interface booth_mul_seq_if #(
   parameter int WIDTH = 8
);
   logic                   in_valid;
   logic                   in_ready;
   logic [WIDTH-1:0]       multiplicand;
   logic [WIDTH-1:0]       multiplier;
   logic                   signed_mode;
   logic                   abort;
   logic                   out_valid;
   logic                   out_ready;
   logic [2*WIDTH-1:0]     product;
   logic                   busy;

   // Operand source / result consumer side.
   modport master (
      output in_valid, multiplicand, multiplier, signed_mode, abort, out_ready,
      input  in_ready, out_valid, product, busy
   );

   // Multiplier side.
   modport slave (
      input  in_valid, multiplicand, multiplier, signed_mode, abort, out_ready,
      output in_ready, out_valid, product, busy
   );
endinterface

// File: rtl/booth_mul_seq.sv
// booth_mul_seq
//   Sequential radix-2 Booth multiplier, one operation in flight.
//   Operands are extended to E = WIDTH+1 bits (sign or zero by signed_mode),
//   so the same signed Booth datapath gives exact results in both modes.
//   E iterations run in CALC; the product is then held in DONE until taken.
//
//   Ports:
//     clk          rising-edge clock
//     rst          synchronous, active-high reset
//     bus          booth_mul_seq_if.slave (operands, handshakes, abort, product)
//     dbg_state_o  current FSM state (0 IDLE, 1 CALC, 2 DONE)
module booth_mul_seq #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   booth_mul_seq_if.slave     bus,
   output logic [1:0]         dbg_state_o
);

   localparam int E  = WIDTH + 1;
   localparam int PW = 2 * E + 1;
   localparam int CW = $clog2(E + 1);
   localparam logic [CW-1:0] LAST_ITER = CW'(E - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [E-1:0]         m_q, m_d;          // extended multiplicand
   logic [PW-1:0]        p_q, p_d;          // {acc, mplr, q}
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   product_q, product_d;

   logic [E-1:0]         acc_cur;
   logic [E-1:0]         acc_new;
   logic [PW-1:0]        p_step;
   logic [E-1:0]         a_ext;
   logic [E-1:0]         b_ext;

   // Extension bit is the operand MSB only in signed mode.
   assign a_ext = {bus.signed_mode & bus.multiplicand[WIDTH-1], bus.multiplicand};
   assign b_ext = {bus.signed_mode & bus.multiplier[WIDTH-1], bus.multiplier};

   // One Booth step: add/subtract M by the {mplr[0], q} pair, then an
   // arithmetic right shift of the whole working register.
   always_comb begin
      acc_cur = p_q[PW-1:E+1];
      acc_new = acc_cur;
      case (p_q[1:0])
         2'b01:   acc_new = acc_cur + m_q;
         2'b10:   acc_new = acc_cur - m_q;
         default: acc_new = acc_cur;
      endcase
      p_step = {acc_new[E-1], acc_new, p_q[E:1]};
   end

   always_comb begin
      state_d   = state_q;
      m_d       = m_q;
      p_d       = p_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      case (state_q)
         S_IDLE: begin
            // abort wins over in_valid: no accept in that cycle.
            if (!bus.abort && bus.in_valid) begin
               m_d     = a_ext;
               p_d     = {{E{1'b0}}, b_ext, 1'b0};
               cnt_d   = '0;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            if (bus.abort) begin
               state_d = S_IDLE;
            end else begin
               p_d   = p_step;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == LAST_ITER) begin
                  // Low 2*WIDTH bits of {acc, mplr} after the final shift.
                  product_d = p_step[2*WIDTH:1];
                  state_d   = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (bus.abort || bus.out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         m_q       <= '0;
         p_q       <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         m_q       <= m_d;
         p_q       <= p_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.busy      = (state_q == S_CALC) || (state_q == S_DONE);
   assign bus.product   = product_q;
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
module tb_booth_mul_seq;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   // 0 = WIDTH 4, 1 = WIDTH 8, 2 = WIDTH 16; only the selected DUT sees
   // in_valid/abort/out_ready.
   logic [1:0]  sel;
   logic        in_valid_c;
   logic [31:0] a_c;
   logic [31:0] b_c;
   logic        sm_c;
   logic        abort_c;
   logic        out_ready_c;

   logic        obs_in_ready;
   logic        obs_out_valid;
   logic        obs_busy;
   logic [31:0] obs_product;

   logic [1:0]  dbg4, dbg8, dbg16;

   booth_mul_seq_if #(.WIDTH(4))  if4 ();
   booth_mul_seq_if #(.WIDTH(8))  if8 ();
   booth_mul_seq_if #(.WIDTH(16)) if16 ();

   booth_mul_seq #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(if4.slave),  .dbg_state_o(dbg4));
   booth_mul_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8.slave),  .dbg_state_o(dbg8));
   booth_mul_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave), .dbg_state_o(dbg16));

   assign if4.in_valid      = in_valid_c & (sel == 2'd0);
   assign if4.abort         = abort_c & (sel == 2'd0);
   assign if4.out_ready     = out_ready_c & (sel == 2'd0);
   assign if4.multiplicand  = a_c[3:0];
   assign if4.multiplier    = b_c[3:0];
   assign if4.signed_mode   = sm_c;

   assign if8.in_valid      = in_valid_c & (sel == 2'd1);
   assign if8.abort         = abort_c & (sel == 2'd1);
   assign if8.out_ready     = out_ready_c & (sel == 2'd1);
   assign if8.multiplicand  = a_c[7:0];
   assign if8.multiplier    = b_c[7:0];
   assign if8.signed_mode   = sm_c;

   assign if16.in_valid     = in_valid_c & (sel == 2'd2);
   assign if16.abort        = abort_c & (sel == 2'd2);
   assign if16.out_ready    = out_ready_c & (sel == 2'd2);
   assign if16.multiplicand = a_c[15:0];
   assign if16.multiplier   = b_c[15:0];
   assign if16.signed_mode  = sm_c;

   always_comb begin
      obs_in_ready  = if16.in_ready;
      obs_out_valid = if16.out_valid;
      obs_busy      = if16.busy;
      obs_product   = if16.product;
      case (sel)
         2'd0: begin
            obs_in_ready  = if4.in_ready;
            obs_out_valid = if4.out_valid;
            obs_busy      = if4.busy;
            obs_product   = {24'd0, if4.product};
         end
         2'd1: begin
            obs_in_ready  = if8.in_ready;
            obs_out_valid = if8.out_valid;
            obs_busy      = if8.busy;
            obs_product   = {16'd0, if8.product};
         end
         default: ;
      endcase
   end

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Plain integer multiplication of the operands as interpreted by mode.
   function automatic logic [31:0] ref_mul(input int w, input logic [31:0] a,
                                           input logic [31:0] b, input bit sm);
      longint mask_in;
      longint sa;
      longint sb;
      longint p;
      mask_in = (longint'(1) << w) - 1;
      sa = longint'({32'd0, a}) & mask_in;
      sb = longint'({32'd0, b}) & mask_in;
      if (sm && sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
      if (sm && sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
      p = (sa * sb) & ((longint'(1) << (2 * w)) - 1);
      return p[31:0];
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present operands for one edge; caller ensures the DUT is in IDLE.
   task automatic drive_accept(input logic [31:0] a, input logic [31:0] b, input bit sm);
      in_valid_c = 1'b1;
      a_c        = a;
      b_c        = b;
      sm_c       = sm;
      tick();
      in_valid_c = 1'b0;
   endtask

   // Count edges after the accept edge until out_valid is seen.  With junk
   // set, operands/mode/in_valid are scrambled each cycle while waiting.
   task automatic wait_out(input int budget, input bit junk, output int edges);
      edges = 0;
      while (!obs_out_valid && edges < budget) begin
         if (junk) begin
            a_c        = $urandom;
            b_c        = $urandom;
            sm_c       = 1'($urandom_range(0, 1));
            in_valid_c = 1'($urandom_range(0, 1));
         end
         tick();
         edges++;
      end
   endtask

   task automatic take();
      out_ready_c = 1'b1;
      tick();
      out_ready_c = 1'b0;
      in_valid_c  = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      tick();
      n_tests++;
      if (obs_in_ready !== 1'b1 || obs_out_valid !== 1'b0 || obs_busy !== 1'b0 || obs_product !== 32'd0) begin
         n_fail++;
         $display("FAIL reset: in_ready=%b out_valid=%b busy=%b product=%h required 1 0 0 0",
                  obs_in_ready, obs_out_valid, obs_busy, obs_product);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_signed_basic();
      int edges;
      sel = 2'd1;
      drive_accept(32'hFD, 32'h05, 1'b1);
      n_tests++;
      if (obs_busy !== 1'b1 || obs_in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL accept_busy: busy=%b in_ready=%b required 1 0", obs_busy, obs_in_ready);
      end
      wait_out(64, 1'b0, edges);
      n_tests++;
      if (edges !== 9) begin
         n_fail++;
         $display("FAIL latency_w8: edges=%0d required 9", edges);
      end
      n_tests++;
      if (obs_product !== 32'h0000FFF1) begin
         n_fail++;
         $display("FAIL signed_m3x5: product=%h required 0000fff1", obs_product);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         n_tests++;
         if (obs_out_valid !== 1'b1 || obs_product !== 32'h0000FFF1 || obs_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_%0d: out_valid=%b in_ready=%b product=%h required 1 0 0000fff1",
                     i, obs_out_valid, obs_in_ready, obs_product);
         end
      end
      take();
      n_tests++;
      if (obs_out_valid !== 1'b0 || obs_in_ready !== 1'b1 || obs_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL after_take: out_valid=%b in_ready=%b busy=%b required 0 1 0",
                  obs_out_valid, obs_in_ready, obs_busy);
      end
   endtask

   task automatic test_corners();
      logic [31:0] a_t[3];
      logic [31:0] b_t[3];
      bit          s_t[3];
      logic [31:0] e_t[3];
      int          edges;
      a_t = '{32'h80, 32'hFF, 32'hFF};
      b_t = '{32'h80, 32'hFF, 32'hFF};
      s_t = '{1'b1, 1'b0, 1'b1};
      e_t = '{32'h4000, 32'hFE01, 32'h0001};
      sel = 2'd1;
      for (int i = 0; i < 3; i++) begin
         drive_accept(a_t[i], b_t[i], s_t[i]);
         wait_out(64, 1'b0, edges);
         n_tests++;
         if (obs_product !== e_t[i] || edges !== 9) begin
            n_fail++;
            $display("FAIL corner_%0d: product=%h edges=%0d required %h 9", i, obs_product, edges, e_t[i]);
         end
         take();
      end
   endtask

   task automatic test_mode_change();
      int edges;
      sel = 2'd1;
      drive_accept(32'd200, 32'd3, 1'b0);
      wait_out(64, 1'b1, edges);
      n_tests++;
      if (obs_product !== 32'h0258 || edges !== 9) begin
         n_fail++;
         $display("FAIL mode_change: product=%h edges=%0d required 0258 9", obs_product, edges);
      end
      take();
   endtask

   task automatic test_reset_mid();
      int edges;
      sel = 2'd1;
      drive_accept(32'hFD, 32'h05, 1'b1);
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_tests++;
      if (obs_in_ready !== 1'b1 || obs_out_valid !== 1'b0 || obs_busy !== 1'b0 || obs_product !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_mid: in_ready=%b out_valid=%b busy=%b product=%h required 1 0 0 0",
                  obs_in_ready, obs_out_valid, obs_busy, obs_product);
      end
      drive_accept(32'd7, 32'd6, 1'b0);
      wait_out(64, 1'b0, edges);
      n_tests++;
      if (obs_product !== 32'h002A || edges !== 9) begin
         n_fail++;
         $display("FAIL after_reset_op: product=%h edges=%0d required 002a 9", obs_product, edges);
      end
      take();
   endtask

   task automatic test_abort();
      int edges;
      bit saw_valid;
      sel = 2'd1;
      // abort in CALC
      drive_accept(32'd9, 32'd9, 1'b0);
      tick();
      tick();
      tick();
      abort_c = 1'b1;
      tick();
      abort_c = 1'b0;
      n_tests++;
      if (obs_in_ready !== 1'b1 || obs_out_valid !== 1'b0 || obs_busy !== 1'b0 || obs_product !== 32'h002A) begin
         n_fail++;
         $display("FAIL abort_calc: in_ready=%b out_valid=%b busy=%b product=%h required 1 0 0 002a",
                  obs_in_ready, obs_out_valid, obs_busy, obs_product);
      end
      // abort together with in_valid in IDLE: no accept
      abort_c    = 1'b1;
      in_valid_c = 1'b1;
      a_c        = 32'd5;
      b_c        = 32'd5;
      tick();
      abort_c    = 1'b0;
      in_valid_c = 1'b0;
      n_tests++;
      if (obs_in_ready !== 1'b1 || obs_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_idle: in_ready=%b busy=%b required 1 0", obs_in_ready, obs_busy);
      end
      saw_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         saw_valid |= obs_out_valid;
      end
      n_tests++;
      if (saw_valid !== 1'b0 || obs_product !== 32'h002A) begin
         n_fail++;
         $display("FAIL abort_quiet: saw_valid=%b product=%h required 0 002a", saw_valid, obs_product);
      end
      // abort in DONE without taking the product
      drive_accept(32'd9, 32'd9, 1'b0);
      wait_out(64, 1'b0, edges);
      n_tests++;
      if (obs_product !== 32'h0051) begin
         n_fail++;
         $display("FAIL abort_prep: product=%h required 0051", obs_product);
      end
      abort_c = 1'b1;
      tick();
      abort_c = 1'b0;
      n_tests++;
      if (obs_out_valid !== 1'b0 || obs_in_ready !== 1'b1 || obs_product !== 32'h0051) begin
         n_fail++;
         $display("FAIL abort_done: out_valid=%b in_ready=%b product=%h required 0 1 0051",
                  obs_out_valid, obs_in_ready, obs_product);
      end
   endtask

   // Random operations with random gaps on both handshakes, scoreboarded.
   task automatic test_sweep(input int w, input bit sm, input int n_ops);
      logic [31:0] exp_q[$];
      logic [31:0] exp_v;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] mask;
      int          edges;
      int          gap;
      sel  = (w == 4) ? 2'd0 : 2'd2;
      mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      for (int k = 0; k < n_ops; k++) begin
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            in_valid_c = 1'b0;
            tick();
         end
         a = $urandom & mask;
         b = $urandom & mask;
         n_tests++;
         if (obs_in_ready !== 1'b1 || obs_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_w%0d_ready op%0d: in_ready=%b out_valid=%b required 1 0",
                     w, k, obs_in_ready, obs_out_valid);
         end
         exp_q.push_back(ref_mul(w, a, b, sm));
         drive_accept(a, b, sm);
         wait_out(4 * w + 16, 1'b1, edges);
         exp_v = exp_q.pop_front();
         n_tests++;
         if (edges !== w + 1 || obs_product !== exp_v || obs_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_w%0d_s%0d op%0d a=%h b=%h: product=%h edges=%0d in_ready=%b required %h %0d 0",
                     w, sm, k, a, b, obs_product, edges, obs_in_ready, exp_v, w + 1);
         end
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) tick();
         n_tests++;
         if (obs_out_valid !== 1'b1 || obs_product !== exp_v) begin
            n_fail++;
            $display("FAIL sweep_w%0d_hold op%0d: out_valid=%b product=%h required 1 %h",
                     w, k, obs_out_valid, obs_product, exp_v);
         end
         take();
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      n_tests     = 0;
      n_fail      = 0;
      sel         = 2'd1;
      in_valid_c  = 1'b0;
      a_c         = '0;
      b_c         = '0;
      sm_c        = 1'b0;
      abort_c     = 1'b0;
      out_ready_c = 1'b0;
      rst         = 1'b1;
      tick();
      tick();
      test_reset();
      test_signed_basic();
      test_corners();
      test_mode_change();
      test_reset_mid();
      test_abort();
      test_sweep(4, 1'b0, 1000);
      test_sweep(4, 1'b1, 1000);
      test_sweep(16, 1'b0, 1000);
      test_sweep(16, 1'b1, 1000);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/booth_mul_seq.md
Name: booth_mul_seq

Overview:
Parametrised sequential radix-2 Booth multiplier: the next generation of the 4-bit lab multiplier. It adds configurable operand width, per-operation signed/unsigned mode, a valid/ready handshake on both sides and an abort input. The block sits between an operand source and a result consumer as a multi-cycle arithmetic unit, with one operation in flight at a time.

Parameters:
WIDTH, 8, operand width in bits (legal range 2..32); product is 2*WIDTH bits.

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  operand pair presented
in_ready  output  1  block can accept operands
multiplicand  input  WIDTH  operand A
multiplier  input  WIDTH  operand B
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled on accept
abort  input  1  cancel the current operation
out_valid  output  1  product valid
out_ready  input  1  consumer takes product
product  output  2*WIDTH  result
busy  output  1  high in CALC or DONE

Behaviour:
- Reset (rst high at a rising edge, from any state, including mid-operation): state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, all internal registers=0. The in-flight operation is discarded.
- Internal extension: each operand is extended to E=WIDTH+1 bits, sign-extended if signed_mode=1 and zero-extended if 0. Working register P is 2E+1 bits: {acc[E], mplr[E], q}.
- States:
  - IDLE: in_ready=1. When in_valid=1 at a rising edge (accept), latch extended multiplicand M, set acc=0, mplr=extended multiplier and q=0, clear the iteration counter, and go to CALC.
  - CALC: in_ready=0. Each cycle, inspect {mplr[0],q}. For 01, acc+=M. For 10, acc-=M. For 00 or 11, no add. All acc arithmetic is E bits modulo 2^E. Then shift {acc,mplr,q} right arithmetically by 1, replicating acc MSB. The counter increments each cycle. After exactly E iterations, go to DONE and load product={acc,mplr}[2*WIDTH-1:0].
  - DONE: out_valid=1 and product held stable until out_ready=1 at a rising edge, then go to IDLE. The product register keeps its last value in IDLE.
- Latency: the accept edge is edge 0. out_valid rises after edge WIDTH+1, so it is first visible in the cycle following edge WIDTH+1. Minimum throughput is one operation per WIDTH+3 cycles.
- Backpressure: out_ready low holds DONE indefinitely. in_ready stays 0 throughout, so no new accept is possible until the product is taken.
- Operands, signed_mode and in_valid are ignored outside IDLE. A change of signed_mode after accept has no effect.
- abort=1 at an edge in CALC or DONE: go to IDLE, out_valid=0, product unchanged. In IDLE, abort has priority over in_valid, so no accept occurs. rst has priority over abort.
- Result is exact for all operand values in both modes, including signed -2^(WIDTH-1)*-2^(WIDTH-1), because of the E-bit extension.
- in_ready and out_valid are never high in the same cycle. busy = state is CALC or DONE.

Test Plan:
1. WIDTH=8, signed, A=-3 (0xFD), B=5 -> out_valid after 9 edges, product=0xFFF1; hold out_ready=0 for 5 cycles -> product and out_valid stable.
2. WIDTH=8, signed, A=0x80, B=0x80 -> product=0x4000. Unsigned, A=0xFF, B=0xFF -> 0xFE01. Signed, A=0xFF, B=0xFF -> 0x0001.
3. WIDTH=8, unsigned, A=200, B=3 -> 0x0258. Toggle signed_mode and operands during CALC -> result unchanged.
4. Assert rst at iteration 4 of an operation -> next cycle in_ready=1, out_valid=0, product=0. Then a new op 7*6 (unsigned) -> 0x002A.
5. Assert abort in CALC, then assert abort together with in_valid in IDLE -> IDLE is reached, no accept occurs, out_valid never rises, product keeps its prior value.
6. WIDTH=4 and WIDTH=16: random sweep of 1000 ops per mode with random in_valid/out_ready gaps, checked against a reference model. Latency is always WIDTH+1, with one accept per completed handshake.
